// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I instruction-fetch slice: FSM state
// encoding, PC increment and the default reset vector.
package rv32i_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DRAIN = 3'd4
   } fetch_state_e;

   localparam int          PC_INC       = 4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg_rv32i.sv
// Program counter: redirect (word-aligned, flags misalignment), sequential
// increment and the combinational pc+4 used by the next-PC mux.
module pc_reg_rv32i
   import rv32i_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_redirect,
   input  logic [WIDTH-1:0] i_target,
   input  logic             i_advance,
   output logic [WIDTH-1:0] o_pc,
   output logic [WIDTH-1:0] o_pc_plus4,
   output logic             o_fetch_err
);

   logic [WIDTH-1:0] r_pc;
   logic             r_fetch_err;
   logic [WIDTH-1:0] w_target_aligned;
   logic             w_misaligned;

   assign w_target_aligned = {i_target[WIDTH-1:2], 2'b00};
   assign w_misaligned     = |i_target[1:0];
   assign o_pc_plus4       = r_pc + WIDTH'(PC_INC);
   assign o_pc             = r_pc;
   assign o_fetch_err      = r_fetch_err;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pc        <= RESET_PC;
         r_fetch_err <= 1'b0;
      end else begin
         r_fetch_err <= i_redirect & w_misaligned;
         if (i_redirect)
            r_pc <= w_target_aligned;
         else if (i_advance)
            r_pc <= o_pc_plus4;
      end
   end

endmodule

// File: rtl/ifetch_rv32i.sv
// RV32I fetch stage: single-outstanding instruction-memory request FSM and
// the IF/ID pipeline register, with flush on redirect and hold on stall.
module ifetch_rv32i
   import rv32i_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_redirect,
   input  logic [WIDTH-1:0] i_pc_target,
   output logic [WIDTH-1:0] o_pc_plus4,
   input  logic             i_stall,
   output logic             o_imem_req,
   output logic [WIDTH-1:0] o_imem_addr,
   input  logic             i_imem_valid,
   input  logic [WIDTH-1:0] i_imem_rdata,
   output logic             o_if_valid,
   output logic [WIDTH-1:0] o_if_pc,
   output logic [WIDTH-1:0] o_if_instr,
   output logic             o_fetch_err
);

   fetch_state_e     r_state;
   fetch_state_e     w_state_nxt;
   logic [WIDTH-1:0] w_pc;
   logic [WIDTH-1:0] r_buf;
   logic             r_if_valid;
   logic [WIDTH-1:0] r_if_pc;
   logic [WIDTH-1:0] r_if_instr;
   logic             w_imem_req;
   logic             w_advance;
   logic             w_load;
   logic [WIDTH-1:0] w_load_data;
   logic             w_buf_we;

   pc_reg_rv32i #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_redirect  (i_redirect),
      .i_target    (i_pc_target),
      .i_advance   (w_advance),
      .o_pc        (w_pc),
      .o_pc_plus4  (o_pc_plus4),
      .o_fetch_err (o_fetch_err)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_imem_req  = 1'b0;
      w_advance   = 1'b0;
      w_load      = 1'b0;
      w_load_data = r_buf;
      w_buf_we    = 1'b0;
      unique case (r_state)
         ST_IDLE: w_state_nxt = ST_REQ;
         ST_REQ: begin
            if (!i_redirect && !i_stall) begin
               w_imem_req  = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_redirect) begin
               w_state_nxt = i_imem_valid ? ST_REQ : ST_DRAIN;
            end else if (i_imem_valid) begin
               if (i_stall) begin
                  w_buf_we    = 1'b1;
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_load      = 1'b1;
                  w_load_data = i_imem_rdata;
                  w_advance   = 1'b1;
                  w_state_nxt = ST_REQ;
               end
            end
         end
         ST_HOLD: begin
            if (i_redirect) begin
               w_state_nxt = ST_REQ;
            end else if (!i_stall) begin
               w_load      = 1'b1;
               w_advance   = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         // A response coinciding with a further redirect still retires the
         // stale request, so leave DRAIN rather than wait for a second one.
         ST_DRAIN: begin
            if (i_imem_valid)
               w_state_nxt = ST_REQ;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_if_valid <= 1'b0;
         r_if_pc    <= '0;
         r_if_instr <= '0;
      end else if (i_redirect) begin
         r_if_valid <= 1'b0;
      end else if (w_load) begin
         r_if_valid <= 1'b1;
         r_if_pc    <= w_pc;
         r_if_instr <= w_load_data;
      end else if (!i_stall) begin
         r_if_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_buf <= '0;
      else if (w_buf_we)
         r_buf <= i_imem_rdata;
   end

   assign o_imem_req  = w_imem_req & ~i_reset;
   assign o_imem_addr = w_pc;
   assign o_if_valid  = r_if_valid;
   assign o_if_pc     = r_if_pc;
   assign o_if_instr  = r_if_instr;

endmodule

// File: tb/tb_ifetch_rv32i.sv
// Self-checking bench for ifetch_rv32i: directed scenarios plus randomized
// redirect/stall/latency traffic against a flag-based fetch model.
module tb_ifetch_rv32i;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_redirect = 1'b0;
   logic [31:0] i_pc_target = '0;
   logic        i_stall = 1'b0;
   logic        i_imem_valid = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic [31:0] o_pc_plus4;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        o_if_valid;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_instr;
   logic        o_fetch_err;

   ifetch_rv32i #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
      .i_clock      (clk),
      .i_reset      (i_reset),
      .i_redirect   (i_redirect),
      .i_pc_target  (i_pc_target),
      .o_pc_plus4   (o_pc_plus4),
      .i_stall      (i_stall),
      .o_imem_req   (o_imem_req),
      .o_imem_addr  (o_imem_addr),
      .i_imem_valid (i_imem_valid),
      .i_imem_rdata (i_imem_rdata),
      .o_if_valid   (o_if_valid),
      .o_if_pc      (o_if_pc),
      .o_if_instr   (o_if_instr),
      .o_fetch_err  (o_fetch_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h0009_E377) ^ 32'h0000_0013;
   endfunction

   // Model: fetch progress tracked as flags (outstanding/discard/buffered).
   bit          m_init = 0, m_started, m_out, m_drop, m_buf_vld, m_ifv, m_err;
   logic [31:0] m_pc, m_buf, m_ifpc, m_ifi;

   function automatic bit model_req();
      return m_started && !m_out && !m_buf_vld && !i_redirect && !i_stall && !i_reset;
   endfunction

   always @(posedge clk) begin
      bit          load, req;
      logic [31:0] ld;
      load = 0;
      ld   = '0;
      req  = model_req();
      if (i_reset) begin
         m_init = 1; m_pc = RST_PC; m_started = 0; m_out = 0; m_drop = 0;
         m_buf_vld = 0; m_buf = '0; m_ifv = 0; m_ifpc = '0; m_ifi = '0; m_err = 0;
      end else if (m_init) begin
         if (i_redirect) begin
            m_err     = (i_pc_target[1:0] != 2'b00);
            m_pc      = i_pc_target & 32'hFFFF_FFFC;
            m_ifv     = 0;
            m_buf_vld = 0;
            m_out     = m_out && !i_imem_valid;
            m_drop    = m_out;
         end else begin
            m_err = 0;
            if (m_out && i_imem_valid) begin
               m_out = 0;
               if (m_drop) m_drop = 0;
               else if (i_stall) begin m_buf = i_imem_rdata; m_buf_vld = 1; end
               else begin load = 1; ld = i_imem_rdata; end
            end else if (m_buf_vld && !i_stall) begin
               load = 1; ld = m_buf; m_buf_vld = 0;
            end else if (req) begin
               m_out = 1;
            end
            if (load) begin
               m_ifv = 1; m_ifpc = m_pc; m_ifi = ld; m_pc = m_pc + 32'd4;
            end else if (!i_stall) begin
               m_ifv = 0;
            end
         end
         m_started = 1;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("m_req", o_imem_req, model_req());
         if (model_req()) chk("m_addr", o_imem_addr, m_pc);
         chk("m_pc_plus4", o_pc_plus4, m_pc + 32'd4);
         chk("m_if_valid", o_if_valid, m_ifv);
         if (m_ifv) begin
            chk("m_if_pc", o_if_pc, m_ifpc);
            chk("m_if_instr", o_if_instr, m_ifi);
         end
         chk("m_fetch_err", o_fetch_err, m_err);
      end
   end

   // Stimulus with a single-outstanding memory of latency lat.
   logic        d_reset = 1'b1, d_redirect = 1'b0, d_stall = 1'b0;
   logic [31:0] d_target = '0;
   int          lat = 1;
   bit          mem_pend = 0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;

   task automatic step();
      @(posedge clk);
      #1;
      i_reset     = d_reset;
      i_redirect  = d_redirect;
      i_pc_target = d_target;
      i_stall     = d_stall;
      if (mem_pend && mem_cnt == 0) begin
         i_imem_valid = 1'b1;
         i_imem_rdata = memword(mem_addr);
         mem_pend     = 0;
      end else begin
         i_imem_valid = 1'b0;
         i_imem_rdata = $urandom;
         if (mem_pend) mem_cnt--;
      end
      @(negedge clk);
      if (o_imem_req) begin
         mem_pend = 1;
         mem_addr = o_imem_addr;
         mem_cnt  = lat - 1;
      end
   endtask

   task automatic wait_req(input int max);
      bit ok;
      ok = 0;
      for (int k = 0; k < max; k++) begin
         step();
         if (o_imem_req) begin ok = 1; break; end
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_req: no imem_req within %0d cycles, required one", max);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset release, 1-cycle memory.
      d_reset = 1; lat = 1;
      step(); step();
      d_reset = 0;
      step();
      chk("rst_req", o_imem_req, 0);
      chk("rst_if_valid", o_if_valid, 0);
      chk("rst_if_pc", o_if_pc, 0);
      chk("rst_if_instr", o_if_instr, 0);
      chk("rst_fetch_err", o_fetch_err, 0);
      chk("rst_pc_plus4", o_pc_plus4, 32'h4);
      step();
      chk("first_req", o_imem_req, 1);
      chk("first_addr", o_imem_addr, 32'h0);
      step();
      chk("wait_if_valid", o_if_valid, 0);
      step();
      chk("t1_if_valid", o_if_valid, 1);
      chk("t1_if_pc", o_if_pc, 32'h0);
      chk("t1_if_instr", o_if_instr, 32'h0000_0013);
      chk("t1_next_addr", o_imem_addr, 32'h4);
      chk("t1_next_req", o_imem_req, 1);

      // Redirect during WAIT, response 3 cycles after the request.
      lat = 3;
      wait_req(10);
      chk("t2_req_addr", o_imem_addr, 32'h8);
      d_redirect = 1; d_target = 32'h100;
      step();
      d_redirect = 0;
      chk("t2_wait_req", o_imem_req, 0);
      step();
      chk("t2_drain_req", o_imem_req, 0);
      chk("t2_drain_ifv", o_if_valid, 0);
      lat = 1;
      step();
      chk("t2_resp_req", o_imem_req, 0);
      chk("t2_resp_ifv", o_if_valid, 0);
      step();
      chk("t2_new_req", o_imem_req, 1);
      chk("t2_new_addr", o_imem_addr, 32'h100);
      chk("t2_ifv", o_if_valid, 0);

      // Stall while the response arrives.
      d_stall = 1;
      step();
      chk("t3_wait_ifv", o_if_valid, 0);
      chk("t3_wait_ifpc", o_if_pc, 32'h4);
      step();
      chk("t3_hold_ifv", o_if_valid, 0);
      chk("t3_hold_ifpc", o_if_pc, 32'h4);
      chk("t3_hold_ifi", o_if_instr, memword(32'h4));
      chk("t3_hold_req", o_imem_req, 0);
      d_stall = 0;
      step();
      chk("t3_rel_req", o_imem_req, 0);
      step();
      chk("t3_ifv", o_if_valid, 1);
      chk("t3_ifpc", o_if_pc, 32'h100);
      chk("t3_ifi", o_if_instr, memword(32'h100));
      chk("t3_next_addr", o_imem_addr, 32'h104);

      // Misaligned redirect.
      d_redirect = 1; d_target = 32'h102;
      step();
      d_redirect = 0;
      chk("t4_req", o_imem_req, 0);
      step();
      chk("t4_err", o_fetch_err, 1);
      chk("t4_req2", o_imem_req, 1);
      chk("t4_addr", o_imem_addr, 32'h100);
      chk("t4_ifv", o_if_valid, 0);
      d_redirect = 1; d_target = 32'hFFFF_FFFC;
      step();
      d_redirect = 0;
      chk("t4_err_pulse", o_fetch_err, 0);

      // Wrap at the top of the address space.
      wait_req(10);
      chk("t5_addr", o_imem_addr, 32'hFFFF_FFFC);
      chk("t5_pc_plus4", o_pc_plus4, 32'h0);
      step();
      step();
      chk("t5_ifv", o_if_valid, 1);
      chk("t5_ifpc", o_if_pc, 32'hFFFF_FFFC);
      chk("t5_next_addr", o_imem_addr, 32'h0);

      // Reset mid-WAIT with a late response.
      step();
      lat = 3;
      wait_req(10);
      chk("t6_req_addr", o_imem_addr, 32'h4);
      d_reset = 1;
      step();
      d_reset = 0;
      step();
      chk("t6_idle_req", o_imem_req, 0);
      chk("t6_idle_ifv", o_if_valid, 0);
      lat = 1;
      step();
      chk("t6_req", o_imem_req, 1);
      chk("t6_addr", o_imem_addr, RST_PC);
      step();
      chk("t6_wait_ifv", o_if_valid, 0);
      step();
      chk("t6_ifv", o_if_valid, 1);
      chk("t6_ifpc", o_if_pc, RST_PC);
      chk("t6_ifi", o_if_instr, 32'h0000_0013);

      // Randomized traffic.
      for (int c = 0; c < 2500; c++) begin
         d_redirect = ($urandom_range(0, 11) == 0);
         d_target   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                   : ($urandom & 32'h0000_0FFF);
         d_stall    = ($urandom_range(0, 3) == 0);
         lat        = $urandom_range(1, 4);
         step();
      end
      d_redirect = 0;
      d_stall    = 0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
